// File: rtl/sprite_layer_engine.sv
// Multi-sprite compositor: N_SPR double-buffered sprite slots, per-slot synchronous ROM
// addressing, priority/colour-key merge over the background, and per-frame collision flags.
module sprite_layer_engine #(
    parameter int          N_SPR       = 4,
    parameter int          W           = 32,
    parameter int          H           = 32,
    parameter int          ROW_W       = 5,
    parameter int          COL_W       = 5,
    parameter logic [11:0] KEY         = 12'hFFF,
    parameter int          COMMIT_LINE = 480
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             bright,
    input  logic [9:0]                       hCount,
    input  logic [9:0]                       vCount,
    input  logic [11:0]                      background,
    input  logic                             wr_en,
    input  logic [2:0]                       wr_sel,
    input  logic [9:0]                       wr_x,
    input  logic [9:0]                       wr_y,
    input  logic                             wr_vis,
    output logic [N_SPR*(ROW_W+COL_W)-1:0]   rom_addr,
    input  logic [N_SPR*12-1:0]              rom_data,
    output logic [11:0]                      rgb,
    output logic                             collision,
    output logic [N_SPR-1:0]                 coll_mask
);

    localparam int AW = ROW_W + COL_W;

    logic [9:0]       r_sh_x  [N_SPR];
    logic [9:0]       r_sh_y  [N_SPR];
    logic             r_sh_vis[N_SPR];
    logic [9:0]       r_act_x [N_SPR];
    logic [9:0]       r_act_y [N_SPR];
    logic             r_act_vis[N_SPR];

    logic [N_SPR-1:0] r_hit;
    logic             r_bright;
    logic [11:0]      r_bg;
    logic             r_coll_acc;
    logic [N_SPR-1:0] r_mask_acc;

    logic             w_commit;
    logic             w_wr_ok;
    logic [N_SPR-1:0] w_hit;
    logic [N_SPR-1:0] w_opq;
    logic [11:0]      w_pix;
    logic             w_found;
    logic [3:0]       w_cnt;
    logic             w_coll_px;
    logic [N_SPR-1:0] w_mask_px;

    assign w_commit = (hCount == 10'd0) && (vCount == 10'(COMMIT_LINE));
    assign w_wr_ok  = wr_en && (32'(wr_sel) < 32'(N_SPR));

    // Commit copies the pre-write shadow: both updates are non-blocking on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_SPR; k++) begin
                r_sh_x[k]    <= '0;
                r_sh_y[k]    <= '0;
                r_sh_vis[k]  <= 1'b0;
                r_act_x[k]   <= '0;
                r_act_y[k]   <= '0;
                r_act_vis[k] <= 1'b0;
            end
        end else begin
            for (int unsigned k = 0; k < N_SPR; k++) begin
                if (w_commit) begin
                    r_act_x[k]   <= r_sh_x[k];
                    r_act_y[k]   <= r_sh_y[k];
                    r_act_vis[k] <= r_sh_vis[k];
                end
                if (w_wr_ok && (32'(wr_sel) == k)) begin
                    r_sh_x[k]   <= wr_x;
                    r_sh_y[k]   <= wr_y;
                    r_sh_vis[k] <= wr_vis;
                end
            end
        end
    end

    for (genvar k = 0; k < N_SPR; k++) begin : g_slot
        logic [ROW_W-1:0] w_row;
        logic [COL_W-1:0] w_col;
        logic             w_in_x;
        logic             w_in_y;

        // 11-bit compares keep x+W / y+H from wrapping past 1023.
        assign w_in_x = ({1'b0, hCount} >= {1'b0, r_act_x[k]}) &&
                        ({1'b0, hCount} <  ({1'b0, r_act_x[k]} + 11'(W)));
        assign w_in_y = ({1'b0, vCount} >= {1'b0, r_act_y[k]}) &&
                        ({1'b0, vCount} <  ({1'b0, r_act_y[k]} + 11'(H)));
        assign w_hit[k] = r_act_vis[k] && w_in_x && w_in_y;

        assign w_row = vCount[ROW_W-1:0] - r_act_y[k][ROW_W-1:0];
        assign w_col = hCount[COL_W-1:0] - r_act_x[k][COL_W-1:0];
        assign rom_addr[k*AW +: AW] = {w_row, w_col};

        assign w_opq[k] = r_hit[k] && (rom_data[k*12 +: 12] != KEY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit    <= '0;
            r_bright <= 1'b0;
            r_bg     <= '0;
        end else begin
            r_hit    <= w_hit;
            r_bright <= bright;
            r_bg     <= background;
        end
    end

    always_comb begin
        w_pix   = r_bg;
        w_found = 1'b0;
        w_cnt   = '0;
        for (int unsigned k = 0; k < N_SPR; k++) begin
            if (w_opq[k]) begin
                w_cnt = w_cnt + 4'd1;
                if (!w_found) begin
                    w_pix   = rom_data[k*12 +: 12];
                    w_found = 1'b1;
                end
            end
        end
        w_coll_px = r_bright && (w_cnt >= 4'd2);
        w_mask_px = w_coll_px ? w_opq : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb <= '0;
        end else begin
            rgb <= r_bright ? w_pix : 12'h000;
        end
    end

    // On commit the current pixel seeds the new frame's accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision  <= 1'b0;
            coll_mask  <= '0;
            r_coll_acc <= 1'b0;
            r_mask_acc <= '0;
        end else if (w_commit) begin
            collision  <= r_coll_acc;
            coll_mask  <= r_mask_acc;
            r_coll_acc <= w_coll_px;
            r_mask_acc <= w_mask_px;
        end else begin
            r_coll_acc <= r_coll_acc | w_coll_px;
            r_mask_acc <= r_mask_acc | w_mask_px;
        end
    end

endmodule

// File: tb/tb_sprite_layer_engine.sv
// Randomized scoreboard bench for sprite_layer_engine with a pixel-rule reference model.
module tb_sprite_layer_engine;

    localparam logic [11:0] KEY = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bright = 1'b0;
    logic [9:0]  hCount = '0;
    logic [9:0]  vCount = '0;
    logic [11:0] background = '0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_sel = '0;
    logic [9:0]  wr_x = '0;
    logic [9:0]  wr_y = '0;
    logic        wr_vis = 1'b0;
    logic [39:0] rom_addr;
    logic [47:0] rom_data = '0;
    logic [11:0] rgb;
    logic        collision;
    logic [3:0]  coll_mask;

    always #5 clk = ~clk;

    sprite_layer_engine #(
        .N_SPR(4), .W(32), .H(32), .ROW_W(5), .COL_W(5),
        .KEY(12'hFFF), .COMMIT_LINE(480)
    ) dut (
        .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
        .background(background), .wr_en(wr_en), .wr_sel(wr_sel), .wr_x(wr_x),
        .wr_y(wr_y), .wr_vis(wr_vis), .rom_addr(rom_addr), .rom_data(rom_data),
        .rgb(rgb), .collision(collision), .coll_mask(coll_mask)
    );

    // Synchronous sprite ROMs, one per slot.
    logic [11:0] rom_mem [4][1024];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            rom_data[k*12 +: 12] <= rom_mem[k][rom_addr[k*10 +: 10]];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { logic [11:0] rgb; int due; int h; int v; } rexp_t;
    typedef struct { logic c; logic [3:0] m; int due; } cexp_t;
    rexp_t qr[$];
    cexp_t qc[$];

    // Reference state
    int sx[4], sy[4], ax[4], ay[4];
    bit sv[4], av[4];
    bit macc, mcoll;
    logic [3:0] mmask, mcmask;
    logic [11:0] bg_cur = 12'h000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        while (qr.size() > 0 && qr[0].due <= cyc) begin
            rexp_t e;
            e = qr.pop_front();
            checks++;
            if (rgb !== e.rgb) begin
                errors++;
                $display("FAIL rgb h=%0d v=%0d: got %h expected %h", e.h, e.v, rgb, e.rgb);
            end
        end
        while (qc.size() > 0 && qc[0].due <= cyc) begin
            cexp_t e;
            e = qc.pop_front();
            checks++;
            if (collision !== e.c || coll_mask !== e.m) begin
                errors++;
                $display("FAIL coll: got %b/%b expected %b/%b", collision, coll_mask, e.c, e.m);
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            sx[k] = 0; sy[k] = 0; sv[k] = 0; ax[k] = 0; ay[k] = 0; av[k] = 0;
        end
        macc = 0; mcoll = 0; mmask = '0; mcmask = '0;
    endtask

    task automatic model_pixel(input int h, input int v, input bit b, input logic [11:0] bg,
                               output logic [11:0] r, output bit c, output logic [3:0] m);
        int n;
        bit found;
        logic [11:0] d;
        n = 0; found = 0; m = '0; r = bg;
        for (int k = 0; k < 4; k++) begin
            if (av[k] && h >= ax[k] && h < ax[k] + 32 && v >= ay[k] && v < ay[k] + 32) begin
                d = rom_mem[k][(v - ay[k]) * 32 + (h - ax[k])];
                if (d != KEY) begin
                    n++;
                    m[k] = 1'b1;
                    if (!found) begin r = d; found = 1; end
                end
            end
        end
        if (!b) r = 12'h000;
        c = b && (n >= 2);
        if (!c) m = '0;
    endtask

    task automatic tick(input int h, input int v, input bit b,
                        input bit we = 0, input int sel = 0, input int x = 0,
                        input int y = 0, input bit vis = 0);
        logic [11:0] er;
        bit ec;
        logic [3:0] em;
        @(negedge clk);
        hCount = 10'(h); vCount = 10'(v); bright = b; background = bg_cur;
        wr_en = we; wr_sel = 3'(sel); wr_x = 10'(x); wr_y = 10'(y); wr_vis = vis;
        model_pixel(h, v, b, bg_cur, er, ec, em);
        if (h == 0 && v == 480) begin
            mcoll = macc; mcmask = mmask; macc = 0; mmask = '0;
            for (int k = 0; k < 4; k++) begin ax[k] = sx[k]; ay[k] = sy[k]; av[k] = sv[k]; end
        end
        if (ec) begin macc = 1; mmask = mmask | em; end
        if (we && sel < 4) begin sx[sel] = x; sy[sel] = y; sv[sel] = vis; end
        qr.push_back('{rgb: er, due: cyc + 2, h: h, v: v});
        qc.push_back('{c: mcoll, m: mcmask, due: cyc + 1});
    endtask

    task automatic idle();
        tick(799, 479, 0);
    endtask

    task automatic pix(input int h, input int v);
        tick(h, v, (h < 640) && (v < 480));
    endtask

    task automatic write_slot(input int sel, input int x, input int y, input bit vis);
        tick(799, 500, 0, 1, sel, x, y, vis);
    endtask

    task automatic commit_frame(input bit we = 0, input int sel = 0, input int x = 0,
                                input int y = 0, input bit vis = 0);
        idle();
        tick(0, 480, 0, we, sel, x, y, vis);
        idle();
    endtask

    task automatic fill_rom(input int k, input logic [11:0] val);
        repeat (3) idle();
        for (int a = 0; a < 1024; a++) rom_mem[k][a] = val;
    endtask

    task automatic scan_box(input int x0, input int y0, input int x1, input int y1, input int n);
        for (int i = 0; i < n; i++)
            pix($urandom_range(x1, x0), $urandom_range(y1, y0));
    endtask

    initial begin
        for (int k = 0; k < 4; k++) fill_rom(k, 12'h000);
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rgb", 32'(rgb), 32'h0);
        check("reset_collision", 32'(collision), 32'h0);
        check("reset_mask", 32'(coll_mask), 32'h0);
        rst = 1'b0;

        // Empty frame over blue background
        bg_cur = 12'h00F;
        for (int i = 0; i < 150; i++) pix($urandom_range(799, 0), $urandom_range(479, 0));
        for (int i = 0; i < 30; i++) pix($urandom_range(799, 640), $urandom_range(524, 1));
        commit_frame();
        check("empty_frame_collision", 32'(collision), 32'h0);

        // Single sprite at (100,50)
        fill_rom(0, 12'h0F0);
        fill_rom(1, 12'hF00);
        write_slot(0, 100, 50, 1);
        commit_frame();
        for (int h = 96; h < 136; h++) begin pix(h, 50); pix(h, 81); pix(h, 49); pix(h, 82); end
        scan_box(90, 40, 140, 90, 100);

        // Overlap with a transparent top sprite, then with an opaque one
        fill_rom(0, KEY);
        write_slot(1, 110, 60, 1);
        commit_frame();
        check("no_coll_single", 32'(collision), 32'h0);
        scan_box(105, 55, 135, 85, 80);
        fill_rom(0, 12'h0F0);
        scan_box(105, 55, 135, 85, 80);
        commit_frame();
        check("overlap_collision", 32'(collision), 32'h1);
        check("overlap_mask", 32'(coll_mask), 32'h3);

        // Write on the commit cycle lands one frame late
        write_slot(1, 0, 0, 0);
        commit_frame(1, 0, 300, 200, 1);
        scan_box(95, 45, 135, 85, 60);
        scan_box(295, 195, 335, 235, 30);
        commit_frame();
        scan_box(95, 45, 135, 85, 30);
        scan_box(295, 195, 335, 235, 60);

        // Right-edge slot must not wrap; out-of-range select ignored
        fill_rom(2, 12'h123);
        write_slot(2, 1000, 0, 1);
        write_slot(5, 20, 20, 1);
        commit_frame();
        for (int h = 0; h < 8; h++) for (int v = 0; v < 4; v++) tick(h, v, 1);
        for (int h = 990; h < 1024; h++) tick(h, 2, 1);
        for (int h = 16; h < 56; h++) tick(h, 25, 1);

        // Randomized frames
        repeat (3) idle();
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 1024; a++)
                rom_mem[k][a] = ($urandom_range(3, 0) == 0) ? KEY : 12'($urandom);
        for (int f = 0; f < 8; f++) begin
            repeat ($urandom_range(4, 1)) begin
                int s;
                s = $urandom_range(7, 0);
                if ($urandom_range(3, 0) == 0)
                    write_slot(s, $urandom_range(1023, 980), $urandom_range(500, 0), 1);
                else
                    write_slot(s, $urandom_range(640, 0), $urandom_range(470, 0),
                               $urandom_range(4, 0) != 0);
            end
            if ($urandom_range(1, 0) == 1)
                write_slot(1, sx[0] + $urandom_range(20, 0), sy[0] + $urandom_range(20, 0), 1);
            commit_frame();
            for (int i = 0; i < 400; i++) begin
                int h, v, k;
                bg_cur = 12'($urandom);
                if ($urandom_range(9, 0) < 7) begin
                    k = $urandom_range(3, 0);
                    h = (ax[k] + $urandom_range(35, 0) - 2) & 1023;
                    v = (ay[k] + $urandom_range(35, 0) - 2) & 1023;
                    if (v > 524) v = $urandom_range(524, 0);
                end else begin
                    h = $urandom_range(1023, 0);
                    v = $urandom_range(524, 0);
                end
                if (h == 0 && v == 480) v = 479;
                tick(h, v, ($urandom_range(9, 0) == 0) ? 1'b1 : ((h < 640) && (v < 480)));
            end
        end
        commit_frame();

        // Mid-line reset with a live collision frame
        bg_cur = 12'h00F;
        fill_rom(0, 12'h0F0);
        fill_rom(1, 12'hF00);
        write_slot(0, 100, 50, 1);
        write_slot(1, 110, 60, 1);
        commit_frame();
        scan_box(110, 60, 131, 81, 20);
        commit_frame();
        check("pre_reset_collision", 32'(collision), 32'h1);
        scan_box(110, 60, 131, 81, 10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_rgb", 32'(rgb), 32'h0);
        check("midreset_collision", 32'(collision), 32'h0);
        check("midreset_mask", 32'(coll_mask), 32'h0);
        qr.delete();
        qc.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        scan_box(100, 50, 141, 91, 40);
        commit_frame();
        scan_box(100, 50, 141, 91, 40);

        repeat (4) idle();
        begin
            int w;
            w = 0;
            while ((qr.size() > 0 || qc.size() > 0) && w < 20) begin
                @(posedge clk);
                w++;
            end
            #2;
            if (qr.size() > 0 || qc.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain: %0d entries left expected 0", qr.size() + qc.size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_layer_engine.md
# sprite_layer_engine

Multi-sprite compositor for the 640x480 VGA pipeline, generalising the single fixed-position sprite overlay. It holds N movable sprite slots with per-frame double-buffered positions, fetches each slot's pixel from an external synchronous ROM, resolves per-pixel priority with colour-key transparency, and flags opaque sprite-to-sprite collisions once per frame. It sits between the background generator and the VGA RGB output register.

## Interface
- N_SPR, 4, number of sprite slots (1..8); slot 0 has the highest priority
- W, 32, sprite width in pixels; W <= 2^COL_W
- H, 32, sprite height in pixels; H <= 2^ROW_W
- ROW_W, 5, ROM row-address width
- COL_W, 5, ROM column-address width
- KEY, 12'hFFF, transparent colour key
- COMMIT_LINE, 480, vCount value at which shadow positions become active
- clk  in  1  pixel clock; one pixel per cycle
- rst  in  1  asynchronous, active-high reset
- bright  in  1  display-area flag aligned with hCount/vCount
- hCount, vCount  in  10 each  current pixel coordinates
- background  in  12  background colour for the current pixel
- wr_en  in  1  shadow-register write strobe
- wr_sel  in  3  slot index to write
- wr_x, wr_y  in  10 each  new top-left position
- wr_vis  in  1  new visibility bit
- rom_addr  out  N_SPR*(ROW_W+COL_W)  per-slot address {row,col}; slot k occupies bits [k*(ROW_W+COL_W) +: ROW_W+COL_W]
- rom_data  in  N_SPR*12  per-slot ROM colour, valid one cycle after the address
- rgb  out  12  composited colour
- collision  out  1  the previous frame had at least one opaque overlap
- coll_mask  out  N_SPR  slots involved in the previous frame's overlaps

## Operation
- Each slot has shadow registers {x,y,vis} and active registers {x,y,vis}. All are 0 at reset, so every slot is invisible.
- On wr_en, the slot wr_sel shadow takes {wr_x,wr_y,wr_vis}. If wr_sel >= N_SPR, the write is ignored.
- Commit happens on the cycle where hCount==0 and vCount==COMMIT_LINE: all active registers load from shadow.
  - If a write coincides with commit, commit takes the old shadow value. The write lands in shadow and takes effect at the next commit.
- Slot k hits the current pixel when all of the following hold: vis_k, x_k <= hCount < x_k+W, and y_k <= vCount < y_k+H.
  - Comparisons use 11-bit arithmetic, so x+W and y+H never wrap.
- rom_addr for slot k is combinational: {vCount-y_k, hCount-x_k}, truncated to ROW_W and COL_W bits. The address is don't-care when the slot does not hit.
- Stage 1 registers the per-slot hit vector, bright and background.
- Stage 2 registers rgb:
  - rgb = 0 when delayed bright is 0.
  - Otherwise rgb = rom_data of the lowest-index slot that hit and whose data != KEY.
  - If no such slot exists, rgb = delayed background. A transparent top sprite falls through to lower slots.
- Collision accumulation:
  - Any stage-2 pixel with bright=1 and two or more opaque hits sets coll_acc.
  - The same pixel ORs the opaque-hit slots into mask_acc.
- At commit, collision and coll_mask load from the accumulators, and both accumulators clear on that same cycle.
  - Accumulation on the commit cycle itself goes to the new frame.

## Timing
- Latency from hCount/vCount/background/bright to rgb is 2 clk cycles. The downstream hsync/vsync path must be delayed by 2 to match.
- rom_data must correspond to the rom_addr driven one cycle earlier (synchronous ROM on clk).
- Reset values: rgb=0, collision=0, coll_mask=0, all pipeline registers 0, all accumulators 0.
- A reset mid-frame blanks rgb from the asserting edge onward. After release, output is background-only until positions are written and committed.
- collision and coll_mask are stable for a full frame and change only on the commit cycle.

## Test plan
- Reset, then run a full frame with background=12'h00F and no writes -> rgb=12'h00F in the display area, 0 outside, collision=0.
- Write slot 0 to (100,50, vis=1) with ROM returning 12'h0F0; commit -> rgb=12'h0F0 for hCount 100..131 and vCount 50..81, appearing 2 cycles after the matching count; background elsewhere.
- Slots 0 and 1 overlap with slot 0 data = KEY and slot 1 data = 12'hF00 -> overlap pixels show 12'hF00. With slot 0 data = 12'h0F0 the same pixels show 12'h0F0, and at the next commit collision=1 and coll_mask=4'b0011.
- Issue wr_en on the exact commit cycle (hCount=0, vCount=480) -> the sprite stays at its old position for the next frame and moves one frame later.
- Set slot 2 to x=1000 with vis=1, and slot 3 with wr_sel=5 -> no wrap artefacts at hCount 0..7, and slot 3 is unchanged.
- Assert rst mid-line -> rgb=0 and collision=0 immediately, and all slots are invisible after release.
